// File: rtl/vending_machine_param.sv
// Parameterised coin-operated vending controller with registered outputs.
// Optional refund-on-cancel support is enabled by defining VEND_CANCEL_EN.
module vending_machine_param #(
   parameter int  N_ITEMS    = 4,
   parameter int  PRICE      = 3,
   parameter int  MAX_CREDIT = 8,
   localparam int SEL_W      = $clog2(N_ITEMS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             coin_valid,
   input  logic [1:0]       coin,
   input  logic             sel_valid,
   input  logic [SEL_W-1:0] sel,
`ifdef VEND_CANCEL_EN
   input  logic             cancel,
`endif
   output logic             coin_reject,
   output logic             short_credit,
   output logic             dispense_valid,
   output logic [SEL_W-1:0] dispense_item,
   input  logic             dispense_ready,
   output logic             change_valid,
   output logic [1:0]       change_coin,
   input  logic             change_ready,
   output logic [4:0]       credit,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

   localparam logic [4:0] PRICE_U = 5'(PRICE);
   localparam logic [5:0] MAX_U   = 6'(MAX_CREDIT);

   state_t           state_q, state_d;
   logic [4:0]       credit_q, credit_d;
   logic [SEL_W-1:0] item_q, item_d;
   logic             coin_reject_q, coin_reject_d;
   logic             short_credit_q, short_credit_d;
   logic             dispense_valid_q, dispense_valid_d;
   logic             change_valid_q, change_valid_d;
   logic [1:0]       change_coin_q, change_coin_d;
   logic             busy_q, busy_d;

   logic       cancel_req;
   logic [2:0] coin_units;
   logic [5:0] credit_sum;
   logic       coin_offered;
   logic       coin_fits;
   logic       sel_in_range;
   logic [4:0] change_step;

`ifdef VEND_CANCEL_EN
   assign cancel_req = cancel;
`else
   assign cancel_req = 1'b0;
`endif

   always_comb begin
      coin_units = 3'd0;
      case (coin)
         2'b01:   coin_units = 3'd1;
         2'b10:   coin_units = 3'd2;
         2'b11:   coin_units = 3'd4;
         default: coin_units = 3'd0;
      endcase
   end

   assign coin_offered = coin_valid && (coin != 2'b00);
   assign credit_sum   = {1'b0, credit_q} + {3'b000, coin_units};
   assign coin_fits    = (credit_sum <= MAX_U);
   assign sel_in_range = (int'(sel) < N_ITEMS);
   assign change_step  = (credit_q >= 5'd2) ? 5'd2 : 5'd1;

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      item_d         = item_q;
      coin_reject_d  = 1'b0;
      short_credit_d = 1'b0;

      case (state_q)
         IDLE, CREDIT: begin
            // Coins and selections are judged independently against the pre-coin credit.
            if (coin_offered) begin
               if (coin_fits) begin
                  credit_d = credit_sum[4:0];
                  state_d  = CREDIT;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
            if (state_q == CREDIT && cancel_req) begin
               state_d = CHANGE;
            end else if (sel_valid && sel_in_range) begin
               if (credit_q >= PRICE_U) begin
                  item_d  = sel;
                  state_d = VEND;
               end else begin
                  short_credit_d = 1'b1;
               end
            end
         end
         VEND: begin
            coin_reject_d = coin_offered;
            if (dispense_ready) begin
               credit_d = credit_q - PRICE_U;
               state_d  = (credit_q == PRICE_U) ? IDLE : CHANGE;
            end
         end
         CHANGE: begin
            coin_reject_d = coin_offered;
            if (change_ready) begin
               credit_d = credit_q - change_step;
               if (credit_q == change_step) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they appear registered.
      dispense_valid_d = (state_d == VEND);
      change_valid_d   = (state_d == CHANGE);
      busy_d           = dispense_valid_d || change_valid_d;
      change_coin_d    = 2'b00;
      if (change_valid_d) begin
         change_coin_d = (credit_d >= 5'd2) ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         credit_q         <= '0;
         item_q           <= '0;
         coin_reject_q    <= 1'b0;
         short_credit_q   <= 1'b0;
         dispense_valid_q <= 1'b0;
         change_valid_q   <= 1'b0;
         change_coin_q    <= 2'b00;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         credit_q         <= credit_d;
         item_q           <= item_d;
         coin_reject_q    <= coin_reject_d;
         short_credit_q   <= short_credit_d;
         dispense_valid_q <= dispense_valid_d;
         change_valid_q   <= change_valid_d;
         change_coin_q    <= change_coin_d;
         busy_q           <= busy_d;
      end
   end

   assign coin_reject    = coin_reject_q;
   assign short_credit   = short_credit_q;
   assign dispense_valid = dispense_valid_q;
   assign dispense_item  = item_q;
   assign change_valid   = change_valid_q;
   assign change_coin    = change_coin_q;
   assign credit         = credit_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param with a cycle-level behavioural model.
// Define VEND_CANCEL_EN to also exercise the cancel/refund path.
module tb_vending_machine_param;

   localparam int N_ITEMS    = 4;
   localparam int PRICE      = 3;
   localparam int MAX_CREDIT = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_valid = 1'b0;
   logic [1:0] coin = 2'b00;
   logic       sel_valid = 1'b0;
   logic [1:0] sel = 2'b00;
`ifdef VEND_CANCEL_EN
   logic       cancel = 1'b0;
`endif
   logic       coin_reject;
   logic       short_credit;
   logic       dispense_valid;
   logic [1:0] dispense_item;
   logic       dispense_ready = 1'b0;
   logic       change_valid;
   logic [1:0] change_coin;
   logic       change_ready = 1'b0;
   logic [4:0] credit;
   logic       busy;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   // Model: credit amount plus whether a product or a refund is in progress.
   int m_credit = 0;
   bit m_vending = 1'b0;
   bit m_refund = 1'b0;
   int m_item = 0;
   bit m_reject = 1'b0;
   bit m_short = 1'b0;

   vending_machine_param #(
      .N_ITEMS(N_ITEMS), .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT)
   ) dut (
      .clk(clk), .rst(rst),
      .coin_valid(coin_valid), .coin(coin),
      .sel_valid(sel_valid), .sel(sel),
`ifdef VEND_CANCEL_EN
      .cancel(cancel),
`endif
      .coin_reject(coin_reject), .short_credit(short_credit),
      .dispense_valid(dispense_valid), .dispense_item(dispense_item),
      .dispense_ready(dispense_ready),
      .change_valid(change_valid), .change_coin(change_coin),
      .change_ready(change_ready),
      .credit(credit), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   always @(posedge clk) begin
      int  c, value;
      bit  v, r, rej, sh, offered, cxl;
      int  it;
      c = m_credit; v = m_vending; r = m_refund; it = m_item;
      rej = 1'b0; sh = 1'b0;
      cxl = 1'b0;
`ifdef VEND_CANCEL_EN
      cxl = cancel;
`endif
      value = (coin == 2'd1) ? 1 : (coin == 2'd2) ? 2 : (coin == 2'd3) ? 4 : 0;
      offered = coin_valid && (coin != 2'd0);
      if (rst) begin
         c = 0; v = 1'b0; r = 1'b0; it = 0;
      end else if (v) begin
         rej = offered;
         if (dispense_ready) begin
            c = c - PRICE; v = 1'b0; r = (c > 0);
         end
      end else if (r) begin
         rej = offered;
         if (change_ready) begin
            c = c - ((c >= 2) ? 2 : 1); r = (c > 0);
         end
      end else begin
         int pre;
         pre = c;
         if (offered) begin
            if (pre + value <= MAX_CREDIT) c = pre + value;
            else rej = 1'b1;
         end
         if (cxl && pre > 0) r = 1'b1;
         else if (sel_valid && int'(sel) < N_ITEMS) begin
            if (pre >= PRICE) begin v = 1'b1; it = int'(sel); end
            else sh = 1'b1;
         end
      end
      m_credit <= c; m_vending <= v; m_refund <= r; m_item <= it;
      m_reject <= rej; m_short <= sh;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_credit", int'(credit), m_credit);
         check("cmp_dispense_valid", int'(dispense_valid), int'(m_vending));
         check("cmp_change_valid", int'(change_valid), int'(m_refund));
         check("cmp_busy", int'(busy), int'(m_vending || m_refund));
         check("cmp_coin_reject", int'(coin_reject), int'(m_reject));
         check("cmp_short_credit", int'(short_credit), int'(m_short));
         check("cmp_exclusive", int'(dispense_valid && change_valid), 0);
         if (m_vending) check("cmp_item", int'(dispense_item), m_item);
         if (m_refund) check("cmp_change_coin", int'(change_coin), (m_credit >= 2) ? 2 : 1);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive_coin(input logic [1:0] c);
      coin_valid = 1'b1; coin = c;
      @(negedge clk);
      coin_valid = 1'b0; coin = 2'b00;
   endtask

   task automatic select(input logic [1:0] s);
      sel_valid = 1'b1; sel = s;
      @(negedge clk);
      sel_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      check("reset_credit", int'(credit), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_dispense", int'(dispense_valid), 0);

      // 5 + 10 rs, exact price, no change
      drive_coin(2'd1);
      drive_coin(2'd2);
      check("exact_credit3", int'(credit), 3);
      dispense_ready = 1'b1;
      select(2'd2);
      check("exact_dispense", int'(dispense_valid), 1);
      check("exact_item", int'(dispense_item), 2);
      tick();
      check("exact_done_dv", int'(dispense_valid), 0);
      check("exact_done_credit", int'(credit), 0);
      check("exact_no_change", int'(change_valid), 0);
      dispense_ready = 1'b0;

      // 20 + 10 rs, change 10 then 5
      drive_coin(2'd3);
      drive_coin(2'd2);
      check("chg_credit6", int'(credit), 6);
      dispense_ready = 1'b1; change_ready = 1'b1;
      select(2'd1);
      check("chg_item", int'(dispense_item), 1);
      tick();
      check("chg_first_coin", int'(change_coin), 2);
      check("chg_credit3", int'(credit), 3);
      tick();
      check("chg_second_coin", int'(change_coin), 1);
      check("chg_credit1", int'(credit), 1);
      tick();
      check("chg_credit0", int'(credit), 0);
      check("chg_idle", int'(busy), 0);
      dispense_ready = 1'b0; change_ready = 1'b0;

      // credit ceiling
      drive_coin(2'd3);
      drive_coin(2'd2);
      drive_coin(2'd1);
      check("ceil_credit7", int'(credit), 7);
      drive_coin(2'd2);
      check("ceil_reject", int'(coin_reject), 1);
      check("ceil_hold7", int'(credit), 7);
      drive_coin(2'd1);
      check("ceil_credit8", int'(credit), 8);
      check("ceil_pulse_once", int'(coin_reject), 0);
      drive_coin(2'd1);
      check("ceil_reject_at8", int'(coin_reject), 1);
      drive_coin(2'd0);
      check("null_coin_no_reject", int'(coin_reject), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("reset_in_credit", int'(credit), 0);

      // short credit, then stalled change hopper
      drive_coin(2'd2);
      select(2'd3);
      check("short_pulse", int'(short_credit), 1);
      check("short_credit2", int'(credit), 2);
      check("short_not_busy", int'(busy), 0);
      tick();
      check("short_once", int'(short_credit), 0);
      drive_coin(2'd3);
      dispense_ready = 1'b1;
      select(2'd0);
      drive_coin(2'd1);
      check("vend_coin_reject", int'(coin_reject), 1);
      dispense_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_coin", int'(change_coin), 2);
         check("stall_credit", int'(credit), 3);
      end
      change_ready = 1'b1;
      tick();
      tick();
      check("stall_drained", int'(credit), 0);
      change_ready = 1'b0;

      // coin and successful selection in the same cycle
      drive_coin(2'd1);
      drive_coin(2'd2);
      dispense_ready = 1'b1; change_ready = 1'b1;
      coin_valid = 1'b1; coin = 2'd1; sel_valid = 1'b1; sel = 2'd3;
      tick();
      coin_valid = 1'b0; coin = 2'd0; sel_valid = 1'b0;
      check("same_item", int'(dispense_item), 3);
      check("same_credit4", int'(credit), 4);
      tick();
      check("same_change5", int'(change_coin), 1);
      tick();
      check("same_idle", int'(credit), 0);
      dispense_ready = 1'b0; change_ready = 1'b0;

      // coin with refused selection: judged on pre-coin credit
      drive_coin(2'd2);
      coin_valid = 1'b1; coin = 2'd1; sel_valid = 1'b1; sel = 2'd0;
      tick();
      coin_valid = 1'b0; coin = 2'd0; sel_valid = 1'b0;
      check("pre_short", int'(short_credit), 1);
      check("pre_credit3", int'(credit), 3);

      // reset while dispensing, with a coin that must be ignored
      select(2'd1);
      tick();
      tick();
      check("stuck_vend", int'(dispense_valid), 1);
      rst = 1'b1; coin_valid = 1'b1; coin = 2'd3;
      tick();
      rst = 1'b0; coin_valid = 1'b0; coin = 2'd0;
      check("rst_vend_dv", int'(dispense_valid), 0);
      check("rst_vend_credit", int'(credit), 0);
      check("rst_vend_busy", int'(busy), 0);
      tick();
      check("rst_coin_ignored", int'(credit), 0);

`ifdef VEND_CANCEL_EN
      drive_coin(2'd3);
      drive_coin(2'd1);
      dispense_ready = 1'b1; change_ready = 1'b1;
      cancel = 1'b1; sel_valid = 1'b1; sel = 2'd0;
      tick();
      cancel = 1'b0; sel_valid = 1'b0;
      check("cxl_no_vend", int'(dispense_valid), 0);
      check("cxl_coin1", int'(change_coin), 2);
      check("cxl_credit5", int'(credit), 5);
      tick();
      check("cxl_coin2", int'(change_coin), 2);
      tick();
      check("cxl_coin3", int'(change_coin), 1);
      tick();
      check("cxl_idle", int'(busy), 0);
      dispense_ready = 1'b0; change_ready = 1'b0;
`endif

      tick();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
